xdma_grant_receiver: RTL and testbench

- Source-side counterpart of the chained-write grant return path.
- At the cluster that originates a chained xDMA write, it tracks one write task from start to last-beat issue.
- It then accepts the grant handshake returned by the next hop and reports task completion to the local frontend.
- A new write task is not started until the previous task's grant has come back.

---
 rtl/xdma_pkg.sv | 13 +
 rtl/xdma_grant_receiver.sv | 109 ++++++++++
 tb/tb_xdma_grant_receiver.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/xdma_pkg.sv
// Shared types and constants for the xDMA chained-write grant path.
package xdma_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSending,
    StWaitGrant,
    StDone
  } xdma_grant_rx_state_t;

  localparam int unsigned XdmaGrantTimeoutDefault = 4096;

endpackage

// File: rtl/xdma_grant_receiver.sv
// Source-side grant receiver: tracks one chained write task until its grant returns.
// Optional grant-wait timeout flag enabled by defining XDMA_GRANT_TIMEOUT_EN.
module xdma_grant_receiver
  import xdma_pkg::*;
#(
  parameter int unsigned TimeoutCycles = XdmaGrantTimeoutDefault,
  parameter int unsigned CntWidth      = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic task_start_valid_i,
  output logic task_start_ready_o,
  input  logic task_last_sent_i,
  input  logic from_remote_grant_valid_i,
  output logic from_remote_grant_ready_o,
  output logic task_done_o,
  output logic busy_o,
  output logic timeout_o
);

  if ((CntWidth < 32) && ((longint'(1) << CntWidth) <= longint'(TimeoutCycles))) begin : g_bad_cfg
    $error("CntWidth too narrow for TimeoutCycles");
  end

  xdma_grant_rx_state_t state_q;
  logic                 early_q;
  logic                 grant_rdy;
  logic                 grant_hs;
  logic                 start_hs;

  // Outputs are pure decodes of registered state, never of valid inputs.
  always_comb begin
    task_start_ready_o = (state_q == StIdle);
    busy_o             = (state_q != StIdle);
    task_done_o        = (state_q == StDone);
    grant_rdy          = 1'b0;
    unique case (state_q)
      StSending:   grant_rdy = !early_q;
      StWaitGrant: grant_rdy = 1'b1;
      default:     grant_rdy = 1'b0;
    endcase
  end

  assign from_remote_grant_ready_o = grant_rdy;
  assign grant_hs = from_remote_grant_valid_i & grant_rdy;
  assign start_hs = task_start_valid_i & task_start_ready_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      early_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_hs) state_q <= StSending;
        end
        StSending: begin
          if (task_last_sent_i) begin
            state_q <= (early_q || grant_hs) ? StDone : StWaitGrant;
          end
          if (grant_hs) early_q <= 1'b1;
        end
        StWaitGrant: begin
          if (grant_hs) state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
          early_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef XDMA_GRANT_TIMEOUT_EN
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                timeout_q, timeout_d;

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (state_q == StDone) begin
      cnt_d = '0;
    end else if ((state_q == StWaitGrant) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (start_hs) begin
      timeout_d = 1'b0;
    end else if ((state_q == StWaitGrant) && (cnt_d >= CntWidth'(TimeoutCycles))) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_xdma_grant_receiver.sv
// Directed self-checking bench for xdma_grant_receiver.
module tb_xdma_grant_receiver;

  logic clk = 1'b0;
  logic rst_n;
  logic start_valid;
  logic start_ready;
  logic last_sent;
  logic grant_valid;
  logic grant_ready;
  logic done;
  logic busy;
  logic timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  xdma_grant_receiver #(
    .TimeoutCycles(8),
    .CntWidth     (16)
  ) dut (
    .clk_i                    (clk),
    .rst_ni                   (rst_n),
    .task_start_valid_i       (start_valid),
    .task_start_ready_o       (start_ready),
    .task_last_sent_i         (last_sent),
    .from_remote_grant_valid_i(grant_valid),
    .from_remote_grant_ready_o(grant_ready),
    .task_done_o              (done),
    .busy_o                   (busy),
    .timeout_o                (timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected vector order: {start_ready, grant_ready, done, busy}
  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {start_ready, grant_ready, done, busy};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_to(input string tag, input logic exp);
    checks++;
    assert (timeout === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, timeout, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    start_valid = 1'b0;
    last_sent   = 1'b0;
    grant_valid = 1'b0;
    tick();
    tick();
    chk("reset_outputs", 4'b1000);
    chk_to("reset_timeout", 1'b0);
    rst_n = 1'b1;

    // Basic task: grant arrives in WAIT_GRANT
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    chk("basic_sending", 4'b0101);
    tick();
    tick();
    chk("basic_sending_hold", 4'b0101);
    last_sent = 1'b1;
    tick();
    last_sent = 1'b0;
    chk("basic_wait", 4'b0101);
    tick();
    tick();
    tick();
    grant_valid = 1'b1;
    tick();
    grant_valid = 1'b0;
    chk("basic_done", 4'b0011);
    tick();
    chk("basic_idle", 4'b1000);
    tick();
    chk("basic_done_single", 4'b1000);

    // Early grant during SENDING, second grant held off
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    grant_valid = 1'b1;
    tick();
    chk("early_ready_drop", 4'b0001);
    tick();
    tick();
    chk("early_second_stalled", 4'b0001);
    grant_valid = 1'b0;
    last_sent   = 1'b1;
    tick();
    last_sent = 1'b0;
    chk("early_done", 4'b0011);
    tick();
    chk("early_idle", 4'b1000);

    // last_sent and grant in the same SENDING cycle
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    last_sent   = 1'b1;
    grant_valid = 1'b1;
    tick();
    last_sent   = 1'b0;
    grant_valid = 1'b0;
    chk("simul_done", 4'b0011);
    tick();
    chk("simul_idle", 4'b1000);

    // Grant in IDLE is back-pressured until the next task starts
    grant_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_idle_hold", 4'b1000);
    end
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    chk("bp_sending", 4'b0101);
    tick();
    grant_valid = 1'b0;
    chk("bp_consumed", 4'b0001);
    last_sent = 1'b1;
    tick();
    last_sent = 1'b0;
    chk("bp_done", 4'b0011);
    tick();
    chk("bp_idle", 4'b1000);

    // last_sent outside SENDING has no effect
    last_sent = 1'b1;
    tick();
    last_sent = 1'b0;
    chk("last_in_idle", 4'b1000);

    // Reset while in WAIT_GRANT
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    last_sent   = 1'b1;
    tick();
    last_sent = 1'b0;
    chk("rst_pre_wait", 4'b0101);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_wait_idle", 4'b1000);
    tick();
    chk("rst_no_done", 4'b1000);

    // Reset with early flag set clears it
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    grant_valid = 1'b1;
    tick();
    grant_valid = 1'b0;
    chk("rst_early_set", 4'b0001);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_early_idle", 4'b1000);
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    chk("rst_early_cleared", 4'b0101);
    last_sent   = 1'b1;
    grant_valid = 1'b1;
    tick();
    last_sent   = 1'b0;
    grant_valid = 1'b0;
    tick();
    chk("rst_early_finish", 4'b1000);

    // Long grant wait: timeout after 8 WAIT_GRANT cycles when enabled
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    last_sent   = 1'b1;
    tick();
    last_sent = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk_to("to_before", 1'b0);
    tick();
`ifdef XDMA_GRANT_TIMEOUT_EN
    chk_to("to_set", 1'b1);
`else
    chk_to("to_absent", 1'b0);
`endif
    chk("to_still_waiting", 4'b0101);
    for (int i = 0; i < 3; i++) tick();
    grant_valid = 1'b1;
    tick();
    grant_valid = 1'b0;
    chk("to_late_done", 4'b0011);
    tick();
    chk("to_idle", 4'b1000);
`ifdef XDMA_GRANT_TIMEOUT_EN
    chk_to("to_sticky", 1'b1);
`else
    chk_to("to_sticky_absent", 1'b0);
`endif
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    chk_to("to_cleared", 1'b0);
    last_sent   = 1'b1;
    grant_valid = 1'b1;
    tick();
    last_sent   = 1'b0;
    grant_valid = 1'b0;
    chk("final_done", 4'b0011);
    tick();
    chk("final_idle", 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
